spart_rx_fifo: RTL and testbench
================================

// Module: spart_rx_fifo
// PURPOSE
// - Parametrised SPART receive path: oversampled asynchronous serial receiver with programmable baud divisor,
//   optional parity, and a receive FIFO.
// - Sits between the rxd pin and the driver-side bus logic; replaces the single-byte receive_buffer/rda path.
// - Adds error flags, false-start rejection and multi-byte buffering.
// PARAMETERS
// - DATA_BITS   8   payload bits per frame, 5..9, LSB first
// - FIFO_DEPTH  4   receive FIFO entries, power of 2, >=2
// - OVERSAMPLE  16  baud ticks per bit period, even, >=4
// - DIV_W       16  width of baud divisor input
// PORTS
// - clk         in   1                      system clock
// - rst         in   1                      synchronous, active-high reset
// - rxd         in   1                      serial input, idle high, asynchronous to clk
// - divisor     in   DIV_W                  baud tick every divisor+1 clocks; sampled on each reload
// - parity_en   in   1                      1 = frame carries a parity bit after the data bits
// - parity_odd  in   1                      1 = odd parity, 0 = even parity; ignored when parity_en=0
// - rd_en       in   1                      pop head of FIFO; ignored when rda=0
// - rd_data     out  DATA_BITS              FIFO head (first-word fall-through), valid when rda=1
// - rda         out  1                      FIFO not empty
// - count       out  $clog2(FIFO_DEPTH+1)   current FIFO occupancy
// - frame_err   out  1                      sticky: stop bit sampled low
// - parity_err  out  1                      sticky: parity mismatch
// - overrun     out  1                      sticky: good frame arrived while FIFO full
// - err_clr     in   1                      clears all three sticky flags
// BEHAVIOUR
// - Reset: rda=0, count=0, rd_data=0, all flags=0, FSM=IDLE, baud counter=0, synchroniser flops=1.
// - rxd passes through a 2-flop synchroniser; all FSM decisions use the synchronised value.
// - Baud tick: down-counter reloads with divisor and pulses tick on reaching 0. divisor=0 gives a tick every clk.
// - The counter free-runs in IDLE and restarts (reload) on start-bit detection, so the frame is phase-aligned.
// - FSM IDLE:   synced rxd falling edge -> START, tick phase counter cleared.
// - FSM START:  after OVERSAMPLE/2 ticks, sample rxd. 0 -> DATA. 1 -> IDLE (false start, no flag).
// - FSM DATA:   sample every OVERSAMPLE ticks, shift in LSB first. After DATA_BITS samples -> PARITY if
//   parity_en, else STOP.
// - FSM PARITY: sample one bit and compare with the XOR of the data bits (inverted for odd parity).
//   Mismatch is recorded -> STOP.
// - FSM STOP:   sample one bit. 0 -> frame_err=1, byte discarded.
//   Else if a parity mismatch was recorded -> parity_err=1, byte discarded.
//   Else push the byte. Always -> IDLE; a new start edge is accepted the cycle after.
// - parity_en and parity_odd are latched at start detection. Changes mid-frame do not affect that frame.
// - Push latency: byte is written on the clk of the stop-sample tick; rda/count update on the next edge.
// - Push while full: if rd_en pops in the same cycle, the push is accepted with no overrun. Otherwise
//   the byte is dropped, overrun=1, and FIFO contents are unchanged.
// - Pop while empty: no effect, count stays 0.
// - Simultaneous push and pop: count unchanged, and ordering is preserved.
// - Pointers wrap modulo FIFO_DEPTH.
// - err_clr in the same cycle as a new error event: the error wins, so the flag stays 1.
// - rst mid-frame: partial frame abandoned, FIFO emptied, state returns to reset values above.
// STRUCTURE
// - spart_pkg: rx_state_t enum {IDLE,START,DATA,PARITY,STOP}; PARITY_EVEN/PARITY_ODD localparams.
// - Sub-module spart_fifo (DATA_WIDTH, DEPTH): synchronous FWFT FIFO with push, pop, full, empty, count.
// - Top level contains the synchroniser, baud counter, bit/tick counters, shift register, FSM and flags.
// TESTING (OVERSAMPLE=16, divisor=0 -> 16 clk/bit, DATA_BITS=8, FIFO_DEPTH=4 unless noted)
// - 8N1 frame 0xA6 on rxd -> rda rises within 1 clk of the stop sample; rd_data=0xA6; count=1; flags 0.
// - parity_en=1, parity_odd=0, frame 0x5A with parity bit 1 (wrong) -> parity_err=1, count stays 0.
// - Frame 0x3C with stop bit driven 0 -> frame_err=1, rda=0. Then err_clr pulse -> frame_err=0.
// - Frames 0x01..0x05 back-to-back, no reads -> overrun=1, count=4. Pops return 0x01,0x02,0x03,0x04 in order.
// - rxd low for 4 clk then high (glitch) -> FSM returns to IDLE, no flags, count=0.
// - rst asserted 1 clk mid-way through the data bits of 0xFF -> rda=0, count=0. Next full frame 0x81
//   is received as 0x81.

Source files
------------

// File: rtl/spart_rx_fifo_pkg.sv
// Shared types for the SPART receive path.
// Receiver FSM states and parity-mode encodings.
package spart_pkg;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP
   } rx_state_t;

   localparam logic PARITY_EVEN = 1'b0;
   localparam logic PARITY_ODD  = 1'b1;

endpackage

// File: rtl/spart_rx_fifo_if.sv
// Driver-side bus of the SPART receive path.
// Read port of the receive FIFO plus sticky error flags.
interface spart_rx_fifo_if #(
   parameter int DATA_BITS  = 8,
   parameter int FIFO_DEPTH = 4
);
   localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

   logic                 rd_en;
   logic                 err_clr;
   logic [DATA_BITS-1:0] rd_data;
   logic                 rda;
   logic [CNT_W-1:0]     count;
   logic                 frame_err;
   logic                 parity_err;
   logic                 overrun;

   modport master (
      output rd_en, err_clr,
      input  rd_data, rda, count,
      input  frame_err, parity_err, overrun
   );

   modport slave (
      input  rd_en, err_clr,
      output rd_data, rda, count,
      output frame_err, parity_err, overrun
   );

endinterface

// File: rtl/spart_fifo.sv
// Synchronous first-word fall-through FIFO.
// Push while full is accepted only when a pop frees the slot.
module spart_fifo #(
   parameter int DATA_WIDTH = 8,
   parameter int DEPTH      = 4,
   localparam int CNT_W     = $clog2(DEPTH + 1)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  push_i,
   input  logic                  pop_i,
   input  logic [DATA_WIDTH-1:0] wdata_i,
   output logic [DATA_WIDTH-1:0] rdata_o,
   output logic                  full_o,
   output logic                  empty_o,
   output logic [CNT_W-1:0]      count_o
);
   localparam int PTR_W = $clog2(DEPTH);

   logic [DATA_WIDTH-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0]      wr_q, rd_q;
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic                  do_push, do_pop;

   assign empty_o = (cnt_q == '0);
   assign full_o  = (cnt_q == CNT_W'(DEPTH));
   assign count_o = cnt_q;
   assign rdata_o = empty_o ? '0 : mem_q[rd_q];

   assign do_pop  = pop_i & ~empty_o;
   assign do_push = push_i & (~full_o | do_pop);

   // Occupancy next-state: simultaneous push and pop leaves it unchanged.
   always_comb begin
      cnt_d = cnt_q;
      if (do_push && !do_pop)
         cnt_d = cnt_q + CNT_W'(1);
      else if (do_pop && !do_push)
         cnt_d = cnt_q - CNT_W'(1);
   end

   // Pointers and count; pointers wrap naturally at DEPTH.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_q  <= '0;
         rd_q  <= '0;
         cnt_q <= '0;
      end else begin
         if (do_push) wr_q <= wr_q + PTR_W'(1);
         if (do_pop)  rd_q <= rd_q + PTR_W'(1);
         cnt_q <= cnt_d;
      end
   end

   // Storage array; contents are don't-care until written.
   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_q] <= wdata_i;
   end

endmodule

// File: rtl/spart_rx_fifo.sv
// SPART receiver: oversampled serial RX with parity and FIFO.
// Frames are phase-aligned by reloading the baud counter at start.
module spart_rx_fifo
   import spart_pkg::*;
#(
   parameter int DATA_BITS  = 8,
   parameter int FIFO_DEPTH = 4,
   parameter int OVERSAMPLE = 16,
   parameter int DIV_W      = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             rxd,
   input  logic [DIV_W-1:0] divisor,
   input  logic             parity_en,
   input  logic             parity_odd,
   spart_rx_fifo_if.slave   bus
);
   localparam int OS_W  = $clog2(OVERSAMPLE);
   localparam int BIT_W = $clog2(DATA_BITS + 1);
   localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
   localparam logic [OS_W-1:0]  HALF_M1  = OS_W'(OVERSAMPLE / 2 - 1);
   localparam logic [OS_W-1:0]  FULL_M1  = OS_W'(OVERSAMPLE - 1);
   localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_BITS - 1);

   logic                 sync1_q, sync2_q, prev_q;
   logic                 rxs, fell;
   logic [DIV_W-1:0]     baud_q, baud_d;
   logic                 tick, restart;
   rx_state_t            state_q, state_d;
   logic [OS_W-1:0]      os_q, os_d;
   logic [BIT_W-1:0]     bit_q, bit_d;
   logic [DATA_BITS-1:0] sh_q, sh_d;
   logic                 pmis_q, pmis_d;
   logic                 pen_q, pen_d;
   logic                 podd_q, podd_d;
   logic                 par_exp;
   logic                 push, pop, full, empty;
   logic                 ferr_ev, perr_ev, ovr_ev;
   logic                 ferr_q, ferr_d;
   logic                 perr_q, perr_d;
   logic                 ovr_q, ovr_d;
   logic [CNT_W-1:0]     fcount;
   logic [DATA_BITS-1:0] rdata;

   assign rxs  = sync2_q;
   assign fell = prev_q & ~sync2_q;
   assign tick = (baud_q == '0);

   assign par_exp = (^sh_q) ^ (podd_q == PARITY_ODD);

   // Two-flop synchroniser plus one history flop for edge detect.
   always_ff @(posedge clk) begin
      if (rst) begin
         sync1_q <= 1'b1;
         sync2_q <= 1'b1;
         prev_q  <= 1'b1;
      end else begin
         sync1_q <= rxd;
         sync2_q <= sync1_q;
         prev_q  <= sync2_q;
      end
   end

   // Baud down-counter: reload on zero or on start detection.
   always_comb begin
      baud_d = baud_q - DIV_W'(1);
      if (restart || tick) baud_d = divisor;
   end

   // Baud counter register.
   always_ff @(posedge clk) begin
      if (rst) baud_q <= '0;
      else     baud_q <= baud_d;
   end

   // Receiver FSM next-state, datapath updates and event pulses.
   always_comb begin
      state_d = state_q;
      os_d    = os_q;
      bit_d   = bit_q;
      sh_d    = sh_q;
      pmis_d  = pmis_q;
      pen_d   = pen_q;
      podd_d  = podd_q;
      restart = 1'b0;
      push    = 1'b0;
      ferr_ev = 1'b0;
      perr_ev = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (fell) begin
               state_d = START;
               os_d    = '0;
               bit_d   = '0;
               pmis_d  = 1'b0;
               pen_d   = parity_en;
               podd_d  = parity_odd;
               restart = 1'b1;
            end
         end
         START: begin
            if (tick) begin
               if (os_q == HALF_M1) begin
                  os_d    = '0;
                  state_d = rxs ? IDLE : DATA;
               end else begin
                  os_d = os_q + OS_W'(1);
               end
            end
         end
         DATA: begin
            if (tick) begin
               if (os_q == FULL_M1) begin
                  os_d  = '0;
                  sh_d  = {rxs, sh_q[DATA_BITS-1:1]};
                  bit_d = bit_q + BIT_W'(1);
                  if (bit_q == LAST_BIT)
                     state_d = pen_q ? PARITY : STOP;
               end else begin
                  os_d = os_q + OS_W'(1);
               end
            end
         end
         PARITY: begin
            if (tick) begin
               if (os_q == FULL_M1) begin
                  os_d    = '0;
                  pmis_d  = (rxs != par_exp);
                  state_d = STOP;
               end else begin
                  os_d = os_q + OS_W'(1);
               end
            end
         end
         STOP: begin
            if (tick) begin
               if (os_q == FULL_M1) begin
                  os_d    = '0;
                  state_d = IDLE;
                  if (!rxs)       ferr_ev = 1'b1;
                  else if (pmis_q) perr_ev = 1'b1;
                  else            push    = 1'b1;
               end else begin
                  os_d = os_q + OS_W'(1);
               end
            end
         end
      endcase
   end

   // Receiver FSM state and datapath registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         os_q    <= '0;
         bit_q   <= '0;
         sh_q    <= '0;
         pmis_q  <= 1'b0;
         pen_q   <= 1'b0;
         podd_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         os_q    <= os_d;
         bit_q   <= bit_d;
         sh_q    <= sh_d;
         pmis_q  <= pmis_d;
         pen_q   <= pen_d;
         podd_q  <= podd_d;
      end
   end

   assign pop    = bus.rd_en & ~empty;
   assign ovr_ev = push & full & ~pop;

   // Sticky flags: a new error event overrides a clear.
   always_comb begin
      ferr_d = (ferr_q & ~bus.err_clr) | ferr_ev;
      perr_d = (perr_q & ~bus.err_clr) | perr_ev;
      ovr_d  = (ovr_q  & ~bus.err_clr) | ovr_ev;
   end

   // Sticky flag registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         ferr_q <= 1'b0;
         perr_q <= 1'b0;
         ovr_q  <= 1'b0;
      end else begin
         ferr_q <= ferr_d;
         perr_q <= perr_d;
         ovr_q  <= ovr_d;
      end
   end

   spart_fifo #(
      .DATA_WIDTH (DATA_BITS),
      .DEPTH      (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .push_i  (push),
      .pop_i   (bus.rd_en),
      .wdata_i (sh_q),
      .rdata_o (rdata),
      .full_o  (full),
      .empty_o (empty),
      .count_o (fcount)
   );

   assign bus.rd_data    = rdata;
   assign bus.rda        = ~empty;
   assign bus.count      = fcount;
   assign bus.frame_err  = ferr_q;
   assign bus.parity_err = perr_q;
   assign bus.overrun    = ovr_q;

endmodule

// File: tb/tb_spart_rx_fifo.sv
// Directed bench for spart_rx_fifo.
// Frames are 16 clk per bit with divisor=0.
module tb_spart_rx_fifo;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        rxd = 1'b1;
   logic [15:0] divisor = '0;
   logic        parity_en = 1'b0;
   logic        parity_odd = 1'b0;
   int          vecs = 0;
   int          errs = 0;

   spart_rx_fifo_if #(.DATA_BITS(8), .FIFO_DEPTH(4)) bus ();

   spart_rx_fifo #(
      .DATA_BITS  (8),
      .FIFO_DEPTH (4),
      .OVERSAMPLE (16),
      .DIV_W      (16)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .rxd        (rxd),
      .divisor    (divisor),
      .parity_en  (parity_en),
      .parity_odd (parity_odd),
      .bus        (bus)
   );

   always #5 clk = ~clk;

   task automatic bit_period(input logic b);
      rxd = b;
      repeat (16) @(negedge clk);
   endtask

   task automatic idle(input int n);
      rxd = 1'b1;
      repeat (n) @(negedge clk);
   endtask

   task automatic send_frame(
      input  logic [7:0] d,
      input  logic       use_par,
      input  logic       pbit,
      input  logic       stopb,
      output int         rise_k
   );
      logic was;
      rise_k = -1;
      bit_period(1'b0);
      for (int i = 0; i < 8; i++) bit_period(d[i]);
      if (use_par) bit_period(pbit);
      rxd = stopb;
      was = bus.rda;
      for (int k = 1; k <= 16; k++) begin
         @(negedge clk);
         if (!was && bus.rda && rise_k < 0) rise_k = k;
      end
      rxd = 1'b1;
   endtask

   task automatic pop_one();
      bus.rd_en = 1'b1;
      @(negedge clk);
      bus.rd_en = 1'b0;
   endtask

   task automatic clr_pulse();
      bus.err_clr = 1'b1;
      @(negedge clk);
      bus.err_clr = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      vecs++;
      if (bus.rda !== 1'b0) begin
         errs++; $display("FAIL reset_rda got %0b want 0", bus.rda);
      end
      vecs++;
      if (bus.count !== 3'd0) begin
         errs++; $display("FAIL reset_count got %0d want 0", bus.count);
      end
      vecs++;
      if (bus.rd_data !== 8'h00) begin
         errs++; $display("FAIL reset_rd_data got %h want 00", bus.rd_data);
      end
      vecs++;
      if ({bus.frame_err, bus.parity_err, bus.overrun} !== 3'b000) begin
         errs++;
         $display("FAIL reset_flags got %b want 000",
                  {bus.frame_err, bus.parity_err, bus.overrun});
      end
   endtask

   task automatic test_8n1();
      int k;
      send_frame(8'hA6, 1'b0, 1'b0, 1'b1, k);
      vecs++;
      if (k < 10 || k > 12) begin
         errs++; $display("FAIL 8n1_rda_latency got %0d want 10..12", k);
      end
      vecs++;
      if (bus.rd_data !== 8'hA6) begin
         errs++; $display("FAIL 8n1_data got %h want a6", bus.rd_data);
      end
      vecs++;
      if (bus.count !== 3'd1) begin
         errs++; $display("FAIL 8n1_count got %0d want 1", bus.count);
      end
      vecs++;
      if ({bus.frame_err, bus.parity_err, bus.overrun} !== 3'b000) begin
         errs++;
         $display("FAIL 8n1_flags got %b want 000",
                  {bus.frame_err, bus.parity_err, bus.overrun});
      end
      pop_one();
      vecs++;
      if (bus.count !== 3'd0 || bus.rda !== 1'b0) begin
         errs++; $display("FAIL 8n1_pop count %0d rda %0b want 0 0",
                          bus.count, bus.rda);
      end
   endtask

   task automatic test_pop_empty();
      pop_one();
      @(negedge clk);
      vecs++;
      if (bus.count !== 3'd0 || bus.rda !== 1'b0) begin
         errs++; $display("FAIL pop_empty count %0d rda %0b want 0 0",
                          bus.count, bus.rda);
      end
   endtask

   task automatic test_parity();
      int k;
      parity_en  = 1'b1;
      parity_odd = 1'b0;
      send_frame(8'h5A, 1'b1, 1'b1, 1'b1, k);
      vecs++;
      if (bus.parity_err !== 1'b1) begin
         errs++; $display("FAIL par_bad_flag got %0b want 1", bus.parity_err);
      end
      vecs++;
      if (bus.count !== 3'd0) begin
         errs++; $display("FAIL par_bad_count got %0d want 0", bus.count);
      end
      clr_pulse();
      send_frame(8'h5A, 1'b1, 1'b0, 1'b1, k);
      vecs++;
      if (bus.rd_data !== 8'h5A || bus.parity_err !== 1'b0) begin
         errs++; $display("FAIL par_good got %h/%0b want 5a/0",
                          bus.rd_data, bus.parity_err);
      end
      pop_one();
      parity_odd = 1'b1;
      send_frame(8'h07, 1'b1, 1'b0, 1'b1, k);
      vecs++;
      if (bus.rd_data !== 8'h07 || bus.parity_err !== 1'b0) begin
         errs++; $display("FAIL par_odd got %h/%0b want 07/0",
                          bus.rd_data, bus.parity_err);
      end
      pop_one();
      parity_en  = 1'b0;
      parity_odd = 1'b0;
   endtask

   task automatic test_frame_err();
      int k;
      send_frame(8'h3C, 1'b0, 1'b0, 1'b0, k);
      idle(8);
      vecs++;
      if (bus.frame_err !== 1'b1) begin
         errs++; $display("FAIL ferr_flag got %0b want 1", bus.frame_err);
      end
      vecs++;
      if (bus.rda !== 1'b0) begin
         errs++; $display("FAIL ferr_rda got %0b want 0", bus.rda);
      end
      clr_pulse();
      vecs++;
      if (bus.frame_err !== 1'b0) begin
         errs++; $display("FAIL ferr_clr got %0b want 0", bus.frame_err);
      end
   endtask

   task automatic test_back_to_back();
      int k;
      logic [7:0] want;
      for (int f = 1; f <= 5; f++) send_frame(8'(f), 1'b0, 1'b0, 1'b1, k);
      idle(8);
      vecs++;
      if (bus.overrun !== 1'b1) begin
         errs++; $display("FAIL b2b_overrun got %0b want 1", bus.overrun);
      end
      vecs++;
      if (bus.count !== 3'd4) begin
         errs++; $display("FAIL b2b_count got %0d want 4", bus.count);
      end
      for (int i = 1; i <= 4; i++) begin
         want = 8'(i);
         vecs++;
         if (bus.rd_data !== want) begin
            errs++; $display("FAIL b2b_pop%0d got %h want %h",
                             i, bus.rd_data, want);
         end
         pop_one();
      end
      vecs++;
      if (bus.count !== 3'd0) begin
         errs++; $display("FAIL b2b_drain got %0d want 0", bus.count);
      end
      clr_pulse();
      vecs++;
      if (bus.overrun !== 1'b0) begin
         errs++; $display("FAIL b2b_clr got %0b want 0", bus.overrun);
      end
   endtask

   task automatic test_glitch();
      int k;
      rxd = 1'b0;
      repeat (4) @(negedge clk);
      idle(40);
      vecs++;
      if ({bus.frame_err, bus.parity_err, bus.overrun} !== 3'b000
          || bus.count !== 3'd0) begin
         errs++; $display("FAIL glitch got flags %b count %0d want 000 0",
                          {bus.frame_err, bus.parity_err, bus.overrun},
                          bus.count);
      end
      send_frame(8'h42, 1'b0, 1'b0, 1'b1, k);
      vecs++;
      if (bus.rd_data !== 8'h42 || bus.count !== 3'd1) begin
         errs++; $display("FAIL glitch_next got %h/%0d want 42/1",
                          bus.rd_data, bus.count);
      end
   endtask

   task automatic test_reset_mid();
      int k;
      vecs++;
      if (bus.rda !== 1'b1) begin
         errs++; $display("FAIL rmid_pre_rda got %0b want 1", bus.rda);
      end
      bit_period(1'b0);
      for (int i = 0; i < 3; i++) bit_period(1'b1);
      repeat (8) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      idle(150);
      vecs++;
      if (bus.rda !== 1'b0 || bus.count !== 3'd0) begin
         errs++; $display("FAIL rmid_empty rda %0b count %0d want 0 0",
                          bus.rda, bus.count);
      end
      send_frame(8'h81, 1'b0, 1'b0, 1'b1, k);
      vecs++;
      if (bus.rd_data !== 8'h81 || bus.count !== 3'd1) begin
         errs++; $display("FAIL rmid_next got %h/%0d want 81/1",
                          bus.rd_data, bus.count);
      end
      pop_one();
   endtask

   initial begin
      bus.rd_en   = 1'b0;
      bus.err_clr = 1'b0;
      test_reset();
      idle(20);
      test_8n1();
      test_pop_empty();
      idle(20);
      test_parity();
      idle(20);
      test_frame_err();
      idle(20);
      test_back_to_back();
      idle(20);
      test_glitch();
      idle(20);
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end

endmodule
